// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32 control path: opcodes, FSM states, opcode classes
// and the datapath select encodings used by the controllers.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_NONE    = 4'd0,
        CLS_R       = 4'd1,
        CLS_IARITH  = 4'd2,
        CLS_LOAD    = 4'd3,
        CLS_STORE   = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_JAL     = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_ILLEGAL = 4'd9
    } class_e;

    localparam logic [1:0] ALU_OP_R      = 2'b00;
    localparam logic [1:0] ALU_OP_ADD    = 2'b01;
    localparam logic [1:0] ALU_OP_IARITH = 2'b10;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b11;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JAL    = 2'b10;

    localparam logic [1:0] WB_SEL_ALU    = 2'b00;
    localparam logic [1:0] WB_SEL_MEM    = 2'b01;
    localparam logic [1:0] WB_SEL_LINK   = 2'b10;

    typedef struct packed {
        logic       alu_src;
        logic [1:0] alu_op;
        logic       alu_en;
    } alu_ctrl_t;

    // ALU operand/operation selects an instruction class holds from EXEC through WB.
    function automatic alu_ctrl_t alu_ctrl_for(class_e cls);
        alu_ctrl_t c;
        c = '0;
        case (cls)
            CLS_R:                c = '{alu_src: 1'b0, alu_op: ALU_OP_R,      alu_en: 1'b0};
            CLS_IARITH:           c = '{alu_src: 1'b1, alu_op: ALU_OP_IARITH, alu_en: 1'b0};
            CLS_LOAD, CLS_STORE:  c = '{alu_src: 1'b1, alu_op: ALU_OP_ADD,    alu_en: 1'b0};
            CLS_BRANCH:           c = '{alu_src: 1'b0, alu_op: ALU_OP_BRANCH, alu_en: 1'b0};
            CLS_LUI:              c = '{alu_src: 1'b1, alu_op: ALU_OP_R,      alu_en: 1'b1};
            CLS_JAL, CLS_AUIPC,
            CLS_ILLEGAL:          c = '{alu_src: 1'b0, alu_op: ALU_OP_R,      alu_en: 1'b1};
            default:              c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rv_opcode_classifier.sv
// Combinational opcode-to-class decode, shared by the single- and multi-cycle controllers.
module rv_opcode_classifier
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [3:0] op_class
);

    always_comb begin
        case (opcode)
            OP_R:      op_class = CLS_R;
            OP_IARITH: op_class = CLS_IARITH;
            OP_LOAD:   op_class = CLS_LOAD;
            OP_STORE:  op_class = CLS_STORE;
            OP_BRANCH: op_class = CLS_BRANCH;
            OP_JAL:    op_class = CLS_JAL;
            OP_LUI:    op_class = CLS_LUI;
            OP_AUIPC:  op_class = CLS_AUIPC;
            default:   op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32 main control sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared
// memory port, with a memory-ready timeout that parks the core in HALT.
module multicycle_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       ir_w,
    output logic       pc_w,
    output logic [1:0] pc_src,
    output logic       mem_addr_sel,
    output logic       mem_r,
    output logic       mem_w,
    output logic       reg_w,
    output logic [1:0] wb_sel,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       alu_en,
    output logic       j_type,
    output logic [2:0] state,
    output logic       illegal,
    output logic       timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    class_e           class_q, class_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [3:0]       cls_raw;
    class_e           cls_dec;
    logic             tmo_hit;
    alu_ctrl_t        alu;

    rv_opcode_classifier u_classifier (
        .opcode   (opcode),
        .op_class (cls_raw)
    );

    assign cls_dec = class_e'(cls_raw);
    assign tmo_hit = (cnt_q == CNT_LAST) && !mem_ready;
    assign alu     = alu_ctrl_for(class_q);
    assign state   = state_q;
    assign timeout = timeout_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            class_q   <= CLS_NONE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // NOTE: every variable gets a default first so no latch is inferred on unlisted paths.
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (tmo_hit) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end
            end
            ST_DECODE: begin
                class_d = cls_dec;
                state_d = (cls_dec == CLS_ILLEGAL) ? ST_FETCH : ST_EXEC;
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_BRANCH:          state_d = ST_FETCH;
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = (class_q == CLS_LOAD) ? ST_WB : ST_FETCH;
                end else if (tmo_hit) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase

        // The wait counter only survives while the FSM sits in the same state.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        ir_w         = 1'b0;
        pc_w         = 1'b0;
        pc_src       = PC_SRC_PLUS4;
        mem_addr_sel = 1'b0;
        mem_r        = 1'b0;
        mem_w        = 1'b0;
        reg_w        = 1'b0;
        wb_sel       = WB_SEL_ALU;
        alu_src      = 1'b0;
        alu_op       = ALU_OP_R;
        alu_en       = 1'b0;
        j_type       = 1'b0;
        illegal      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_r = 1'b1;
                ir_w  = mem_ready;
                pc_w  = mem_ready;
            end
            ST_DECODE: illegal = (cls_dec == CLS_ILLEGAL);
            ST_EXEC: begin
                alu_src = alu.alu_src;
                alu_op  = alu.alu_op;
                alu_en  = alu.alu_en;
                j_type  = (class_q == CLS_JAL);
                if (class_q == CLS_BRANCH) begin
                    pc_w   = branch_taken;
                    pc_src = PC_SRC_BRANCH;
                end
            end
            ST_MEM: begin
                mem_addr_sel = 1'b1;
                alu_src      = 1'b1;
                alu_op       = ALU_OP_ADD;
                mem_r        = (class_q == CLS_LOAD);
                mem_w        = (class_q == CLS_STORE);
            end
            ST_WB: begin
                reg_w   = 1'b1;
                alu_src = alu.alu_src;
                alu_op  = alu.alu_op;
                alu_en  = alu.alu_en;
                if (class_q == CLS_LOAD) begin
                    wb_sel = WB_SEL_MEM;
                end else if (class_q == CLS_JAL) begin
                    wb_sel = WB_SEL_LINK;
                    pc_w   = 1'b1;
                    pc_src = PC_SRC_JAL;
                    j_type = 1'b1;
                end
            end
            default: ;
        endcase

        // Any in-flight access or pulse is squashed for as long as reset is held.
        if (reset) begin
            ir_w         = 1'b0;
            pc_w         = 1'b0;
            pc_src       = PC_SRC_PLUS4;
            mem_addr_sel = 1'b0;
            mem_r        = 1'b0;
            mem_w        = 1'b0;
            reg_w        = 1'b0;
            wb_sel       = WB_SEL_ALU;
            alu_src      = 1'b0;
            alu_op       = ALU_OP_R;
            alu_en       = 1'b0;
            j_type       = 1'b0;
            illegal      = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: a per-cycle vector table for instruction flows
// plus hand-written sequences for timeout, HALT and reset in the middle of an access.
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_w;
        logic       pc_w;
        logic [1:0] pc_src;
        logic       mas;
        logic       mem_r;
        logic       mem_w;
        logic       reg_w;
        logic [1:0] wb_sel;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       alu_en;
        logic       j_type;
        logic       illegal;
        logic       timeout;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic       rdy;
        logic       bt;
        outs_t      exp;
    } vec_t;

    logic       clk, reset, mem_ready, branch_taken;
    logic [6:0] opcode;
    logic       ir_w, pc_w, mem_addr_sel, mem_r, mem_w, reg_w, alu_src, alu_en, j_type;
    logic       illegal, timeout;
    logic [1:0] pc_src, wb_sel, alu_op;
    logic [2:0] state;
    outs_t      outs;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[64];
    int nv = 0;

    multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .ir_w(ir_w), .pc_w(pc_w), .pc_src(pc_src),
        .mem_addr_sel(mem_addr_sel), .mem_r(mem_r), .mem_w(mem_w), .reg_w(reg_w),
        .wb_sel(wb_sel), .alu_src(alu_src), .alu_op(alu_op), .alu_en(alu_en),
        .j_type(j_type), .state(state), .illegal(illegal), .timeout(timeout)
    );

    assign outs = {state, ir_w, pc_w, pc_src, mem_addr_sel, mem_r, mem_w, reg_w,
                   wb_sel, alu_src, alu_op, alu_en, j_type, illegal, timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic outs_t e(logic [2:0] st, logic ir, logic pw, logic [1:0] ps,
                                logic mas, logic mr, logic mw, logic rw, logic [1:0] wb,
                                logic as, logic [1:0] ao, logic ae, logic jt, logic il);
        return {st, ir, pw, ps, mas, mr, mw, rw, wb, as, ao, ae, jt, il, 1'b0};
    endfunction

    task automatic add(input logic [6:0] op, input logic rdy, input logic bt, input outs_t x);
        vecs[nv] = '{op: op, rdy: rdy, bt: bt, exp: x};
        nv++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    initial begin
        outs_t f_go, f_wait, dec, zero;
        int    n;

        reset = 1'b1; opcode = 7'b0110011; mem_ready = 1'b1; branch_taken = 1'b0;
        f_go   = e(3'd0, 1, 1, 2'b00, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        f_wait = e(3'd0, 0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        dec    = e(3'd1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        zero   = '0;

        // R-type: 0,1,2,4
        add(7'b0110011, 1, 0, f_go);
        add(7'b0110011, 1, 0, dec);
        add(7'b0110011, 1, 0, e(3'd2, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0));
        add(7'b0110011, 1, 0, e(3'd4, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 2'b00, 0, 0, 0));
        // LOAD with three MEM wait cycles: 8 cycles total
        add(7'b0000011, 1, 0, f_go);
        add(7'b0000011, 1, 0, dec);
        add(7'b0000011, 1, 0, e(3'd2, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b01, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            add(7'b0000011, 0, 0, e(3'd3, 0, 0, 2'b00, 1, 1, 0, 0, 2'b00, 1, 2'b01, 0, 0, 0));
        add(7'b0000011, 1, 0, e(3'd3, 0, 0, 2'b00, 1, 1, 0, 0, 2'b00, 1, 2'b01, 0, 0, 0));
        add(7'b0000011, 1, 0, e(3'd4, 0, 0, 2'b00, 0, 0, 0, 1, 2'b01, 1, 2'b01, 0, 0, 0));
        // BRANCH taken, then not taken
        add(7'b1100011, 1, 1, f_go);
        add(7'b1100011, 1, 1, dec);
        add(7'b1100011, 1, 1, e(3'd2, 0, 1, 2'b01, 0, 0, 0, 0, 2'b00, 0, 2'b11, 0, 0, 0));
        add(7'b1100011, 1, 0, f_go);
        add(7'b1100011, 1, 0, dec);
        add(7'b1100011, 1, 0, e(3'd2, 0, 0, 2'b01, 0, 0, 0, 0, 2'b00, 0, 2'b11, 0, 0, 0));
        // JAL
        add(7'b1101111, 1, 0, f_go);
        add(7'b1101111, 1, 0, dec);
        add(7'b1101111, 1, 0, e(3'd2, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 1, 0));
        add(7'b1101111, 1, 0, e(3'd4, 0, 1, 2'b10, 0, 0, 0, 1, 2'b10, 0, 2'b00, 1, 1, 0));
        // Illegal opcode: 2 cycles, one-cycle pulse in DECODE
        add(7'b1111111, 1, 0, f_go);
        add(7'b1111111, 1, 0, e(3'd1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 1));
        // STORE with one FETCH wait cycle
        add(7'b0100011, 0, 0, f_wait);
        add(7'b0100011, 1, 0, f_go);
        add(7'b0100011, 1, 0, dec);
        add(7'b0100011, 1, 0, e(3'd2, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b01, 0, 0, 0));
        add(7'b0100011, 1, 0, e(3'd3, 0, 0, 2'b00, 1, 0, 1, 0, 2'b00, 1, 2'b01, 0, 0, 0));
        // LUI
        add(7'b0110111, 1, 0, f_go);
        add(7'b0110111, 1, 0, dec);
        add(7'b0110111, 1, 0, e(3'd2, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b00, 1, 0, 0));
        add(7'b0110111, 1, 0, e(3'd4, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 1, 2'b00, 1, 0, 0));
        // IARITH
        add(7'b0010011, 1, 0, f_go);
        add(7'b0010011, 1, 0, dec);
        add(7'b0010011, 1, 0, e(3'd2, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2'b10, 0, 0, 0));
        add(7'b0010011, 1, 0, e(3'd4, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 1, 2'b10, 0, 0, 0));
        add(7'b0010011, 0, 0, f_wait);

        // Reset state: strobes forced low while reset is held, even with mem_ready high
        step();
        @(negedge clk);
        check("reset_outputs", 32'(outs), 32'(zero));
        step();
        reset = 1'b0;

        for (int i = 0; i < nv; i++) begin
            opcode = vecs[i].op; mem_ready = vecs[i].rdy; branch_taken = vecs[i].bt;
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
            if (mem_r && mem_w) check("mem_rw_exclusive", 32'(1), 32'(0));
            step();
        end

        // Timeout in FETCH: HALT after exactly 16 wait cycles
        apply_reset();
        mem_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (state == 3'd5) break;
            n++;
            step();
        end
        check("timeout_cycles", 32'(n), 32'(16));
        check("halt_outputs", 32'(outs), 32'(e(3'd5, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0)) | 32'd1);
        mem_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("halt_holds_state", 32'(state), 32'(5));
        check("halt_holds_timeout", 32'(timeout), 32'(1));
        check("halt_no_mem_r", 32'(mem_r), 32'(0));

        apply_reset();
        @(negedge clk);
        check("reset_from_halt_state", 32'(state), 32'(0));
        check("reset_clears_timeout", 32'(timeout), 32'(0));

        // mem_ready on the last tolerated cycle wins over the timeout
        step();
        apply_reset();
        mem_ready = 1'b0;
        repeat (15) step();
        mem_ready = 1'b1;
        @(negedge clk);
        check("late_ready_ir_w", 32'(ir_w), 32'(1));
        step();
        @(negedge clk);
        check("late_ready_decode", 32'(state), 32'(1));
        check("late_ready_no_timeout", 32'(timeout), 32'(0));

        // Reset in the middle of a stalled load
        apply_reset();
        opcode = 7'b0000011; mem_ready = 1'b1;
        repeat (3) step();
        mem_ready = 1'b0;
        @(negedge clk);
        check("midload_in_mem", 32'(state), 32'(3));
        check("midload_mem_r", 32'(mem_r), 32'(1));
        reset = 1'b1;
        @(negedge clk);
        check("midload_mem_r_dropped", 32'(mem_r), 32'(0));
        step();
        reset = 1'b0;
        @(negedge clk);
        check("midload_back_to_fetch", 32'(state), 32'(0));
        check("midload_no_timeout", 32'(timeout), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Multi-cycle main control sequencer for the RV32 core. It replaces single-cycle opcode decode with a FETCH/DECODE/EXEC/MEM/WB state machine so that one shared memory port serves both instruction fetch and load/store. It drives per-state datapath strobes and waits on a memory-ready handshake. It halts on a memory timeout and flags illegal opcodes.

Parameters:
TIMEOUT_CYCLES, 16, consecutive mem_ready-low cycles tolerated in FETCH or MEM before entering HALT (minimum 2)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
opcode  in  7  instr[6:0] from the instruction register; sampled in DECODE
mem_ready  in  1  memory completes the current read/write this cycle
branch_taken  in  1  ALU compare result; valid in EXEC
ir_w  out  1  load the instruction register
pc_w  out  1  write PC
pc_src  out  2  00 PC+4, 01 branch target, 10 JAL target
mem_addr_sel  out  1  0 PC, 1 ALU result
mem_r  out  1  memory read strobe
mem_w  out  1  memory write strobe
reg_w  out  1  register file write
wb_sel  out  2  00 ALU, 01 memory data, 10 link (old PC+4)
alu_src  out  1  0 rs2, 1 immediate
alu_op  out  2  {ALU1,ALU0}: 00 R-type, 01 load/store add, 10 I-arith, 11 branch
alu_en  out  1  1 for JAL/LUI/AUIPC/illegal; 0 otherwise
j_type  out  1  JAL in progress
state  out  3  current state, for debug
illegal  out  1  one-cycle pulse on an unrecognised opcode
timeout  out  1  sticky; set on entering HALT

Behaviour:
- Reset: state=FETCH, class=NONE, timeout counter=0, timeout=0, illegal=0. While reset is high, all strobes are forced to 0.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Unused codes go to FETCH.
- Opcode classes, latched in DECODE into a class register: R 0110011, IARITH 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, LUI 0110111, AUIPC 0010111, anything else ILLEGAL.
- Unless stated otherwise, outputs depend on state and latched class. ir_w and pc_w in FETCH also depend on mem_ready.
- FETCH: mem_r=1, mem_addr_sel=0.
  - mem_ready=1: ir_w=1, pc_w=1, pc_src=00, go to DECODE.
  - mem_ready=0: stay in FETCH.
- DECODE: no strobes. Legal class goes to EXEC. ILLEGAL pulses illegal=1 for one cycle, goes to FETCH, and the instruction executes as a NOP (PC already advanced).
- EXEC: alu_src/alu_op per class (R 0/00, IARITH 1/10, LOAD/STORE 1/01, BRANCH 0/11). LUI sets alu_src=1; AUIPC and JAL set alu_src=0. alu_en=1 for JAL/LUI/AUIPC. j_type=1 for JAL.
  - BRANCH: pc_w=branch_taken, pc_src=01, go to FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM: mem_addr_sel=1, with alu_src/alu_op held at 1/01.
  - LOAD: mem_r=1; on mem_ready go to WB.
  - STORE: mem_w=1; on mem_ready go to FETCH.
- WB: reg_w=1 for exactly one cycle, then FETCH.
  - wb_sel: LOAD 01, JAL 10, else 00.
  - JAL also drives pc_w=1, pc_src=10, j_type=1.
  - alu_src/alu_op/alu_en stay at their EXEC values.
- Timeout:
  - The counter increments each cycle in FETCH or MEM with mem_ready=0 and clears on any state change.
  - If the counter equals TIMEOUT_CYCLES-1 and mem_ready=0, go to HALT and set timeout=1. If mem_ready=1 in that same cycle, mem_ready wins and the normal transition occurs.
- HALT: all strobes 0; the state holds until reset.
- Reset mid-access: the next edge forces FETCH and counter=0 regardless of mem_ready. Any in-flight mem_r/mem_w drops while reset is high.
- Latency with zero-wait memory (mem_ready=1 on the first cycle):
  - R/IARITH/LUI/AUIPC/JAL/STORE: 4 cycles
  - LOAD: 5 cycles
  - BRANCH: 3 cycles
  - ILLEGAL: 2 cycles
- Each memory wait cycle adds one cycle.
- Invariants: mem_r and mem_w are never both high; reg_w is only high in WB.

Decomposition:
- Shared package rv_ctrl_pkg: opcode constants, state enum, class enum, alu_op encodings, pc_src/wb_sel encodings.
- Sub-module: rv_opcode_classifier, combinational opcode-to-class decode, reusable by the single-cycle controller.

Test Plan:
- Reset, then R-type 0110011 with mem_ready tied 1 → states 0,1,2,4,0; ir_w/pc_w high in cycle 0; reg_w high only in cycle 3 with wb_sel=00, alu_op=00.
- LOAD 0000011 with mem_ready low 3 cycles in MEM → MEM lasts 4 cycles with mem_r=1, mem_addr_sel=1; WB wb_sel=01; total 8 cycles.
- BRANCH with branch_taken=1, then again with branch_taken=0 → EXEC pc_w=1/pc_src=01, then pc_w=0; both return to FETCH after 3 cycles; reg_w never high.
- JAL 1101111 → WB has reg_w=1, wb_sel=10, pc_w=1, pc_src=10, j_type=1.
- Opcode 1111111 → illegal pulses exactly one cycle in DECODE, state returns to FETCH, no reg_w or mem_w.
- mem_ready held 0 in FETCH with TIMEOUT_CYCLES=16 → HALT after 16 cycles, timeout=1, all strobes 0. Variant with mem_ready=1 on cycle 16 → DECODE, no timeout. Then reset → FETCH, timeout=0.
